// File: rtl/tec_bus_pkg.sv
// Shared types and packet-field helpers for the round-robin terminal crossbar.
package tec_bus_pkg;

    localparam int PKT_W_DEF = 65;
    localparam int MAX_PKT_W = 512;
    localparam int FIELD_W   = 8;

    typedef logic [PKT_W_DEF-1:0] pkt_t;

    function automatic int unsigned broadcast_id(input int unsigned id_w);
        return (32'd1 << id_w) - 32'd1;
    endfunction

    // Extracts a field of up to FIELD_W bits starting at bit lsb (target or source).
    function automatic logic [FIELD_W-1:0] pkt_field(input logic [MAX_PKT_W-1:0] pkt,
                                                     input int lsb, input int width);
        logic [FIELD_W-1:0] f;
        f = '0;
        for (int b = 0; b < FIELD_W; b++) begin
            if (b < width && (lsb + b) < MAX_PKT_W) f[b] = pkt[lsb + b];
        end
        return f;
    endfunction

endpackage

// File: rtl/tec_bus_fifo.sv
// Show-ahead FIFO; dout keeps the last popped entry while empty (zero after reset).
module tec_bus_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] last_q;
    logic             wr_en, rd_en;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = empty ? last_q : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + AW'(1);
            end
            if (rd_en) begin
                rd_q   <= rd_q + AW'(1);
                last_q <= mem_q[rd_q];
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tec_bus_rr_xbar.sv
// N_TERM-terminal round-robin packet crossbar with unicast, broadcast and invalid-target drop.
// Optional statistics counters are built when TEC_BUS_STATS_EN is defined.
module tec_bus_rr_xbar
    import tec_bus_pkg::*;
#(
    parameter int N_TERM  = 4,
    parameter int PCKG_SZ = 65,
    parameter int ID_W    = 3,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_TERM-1:0]          push,
    input  logic [N_TERM*PCKG_SZ-1:0]  D_push,
    output logic [N_TERM-1:0]          full,
    input  logic [N_TERM-1:0]          pop,
    output logic [N_TERM*PCKG_SZ-1:0]  D_pop,
    output logic [N_TERM-1:0]          pndng,
    output logic [N_TERM-1:0]          ovf,
`ifdef TEC_BUS_STATS_EN
    output logic [N_TERM*32-1:0]       xfer_cnt,
    output logic [31:0]                stall_cnt,
`endif
    output logic [15:0]                drop_cnt
);

    localparam int PW      = $clog2(N_TERM);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int TGT_LSB = PCKG_SZ - ID_W;
    localparam logic [FIELD_W-1:0] BCAST = FIELD_W'(broadcast_id(ID_W));

    logic [PCKG_SZ-1:0] in_head [N_TERM];
    logic [CW-1:0]      in_cnt_unused  [N_TERM];
    logic [CW-1:0]      out_cnt_unused [N_TERM];
    logic [N_TERM-1:0]  in_full, in_empty, in_pop;
    logic [N_TERM-1:0]  out_full, out_empty, out_push;

    logic [FIELD_W-1:0] tgt  [N_TERM];
    logic [N_TERM-1:0]  dest [N_TERM];
    logic [N_TERM-1:0]  cand, is_drop;

    logic               gnt_vld, gnt_drop;
    logic [PW-1:0]      gnt_idx;
    logic [PCKG_SZ-1:0] xfer_pkt;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [N_TERM-1:0]  ovf_q;
    logic [15:0]        drop_q;

    for (genvar g = 0; g < N_TERM; g++) begin : g_term
        tec_bus_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_in (
            .clk   (clk),
            .reset (reset),
            .push  (push[g]),
            .pop   (in_pop[g]),
            .din   (D_push[g*PCKG_SZ +: PCKG_SZ]),
            .dout  (in_head[g]),
            .full  (in_full[g]),
            .empty (in_empty[g]),
            .count (in_cnt_unused[g])
        );

        tec_bus_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_out (
            .clk   (clk),
            .reset (reset),
            .push  (out_push[g]),
            .pop   (pop[g]),
            .din   (xfer_pkt),
            .dout  (D_pop[g*PCKG_SZ +: PCKG_SZ]),
            .full  (out_full[g]),
            .empty (out_empty[g]),
            .count (out_cnt_unused[g])
        );
    end

    // Destination mask per input head; an empty mask means the packet is discarded.
    always_comb begin
        for (int i = 0; i < N_TERM; i++) begin
            tgt[i]     = pkt_field(MAX_PKT_W'(in_head[i]), TGT_LSB, ID_W);
            dest[i]    = '0;
            is_drop[i] = 1'b0;
            if (tgt[i] < FIELD_W'(N_TERM)) begin
                for (int j = 0; j < N_TERM; j++) dest[i][j] = (tgt[i] == FIELD_W'(j));
            end else if (tgt[i] == BCAST) begin
                for (int j = 0; j < N_TERM; j++) dest[i][j] = (j != i);
            end else begin
                is_drop[i] = 1'b1;
            end
            cand[i] = !in_empty[i] && ((dest[i] & out_full) == '0);
        end
    end

    always_comb begin
        int s;
        s        = 0;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        for (int k = 0; k < N_TERM; k++) begin
            s = int'(ptr_q) + k;
            if (s >= N_TERM) s = s - N_TERM;
            if (!gnt_vld && cand[PW'(s)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(s);
            end
        end
        xfer_pkt = in_head[gnt_idx];
        gnt_drop = gnt_vld && is_drop[gnt_idx];
        out_push = gnt_vld ? dest[gnt_idx] : '0;
        for (int j = 0; j < N_TERM; j++) in_pop[j] = gnt_vld && (gnt_idx == PW'(j));
        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = (int'(gnt_idx) == N_TERM - 1) ? '0 : gnt_idx + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            ovf_q  <= '0;
            drop_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_q | (push & in_full);
            if (gnt_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign full     = in_full;
    assign pndng    = ~out_empty;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;

`ifdef TEC_BUS_STATS_EN
    logic [31:0] xfer_q [N_TERM];
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_TERM; i++) xfer_q[i] <= '0;
            stall_q <= '0;
        end else begin
            if (gnt_vld && !gnt_drop) xfer_q[gnt_idx] <= xfer_q[gnt_idx] + 32'd1;
            if ((|(~in_empty)) && !gnt_vld) stall_q <= stall_q + 32'd1;
        end
    end

    for (genvar g = 0; g < N_TERM; g++) begin : g_stat
        assign xfer_cnt[g*32 +: 32] = xfer_q[g];
    end
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_tec_bus_rr_xbar.sv
// Directed bench for tec_bus_rr_xbar: vector table plus fairness, backpressure and reset sequences.
module tb_tec_bus_rr_xbar;

    localparam int N   = 4;
    localparam int W   = 65;
    localparam int IDW = 3;
    localparam int DEP = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     push, pop, full, pndng, ovf;
    logic [N*W-1:0]   D_push, D_pop;
    logic [15:0]      drop_cnt;

    int total = 0;
    int bad   = 0;

    tec_bus_rr_xbar #(.N_TERM(N), .PCKG_SZ(W), .ID_W(IDW), .DEPTH(DEP)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .D_push   (D_push),
        .full     (full),
        .pop      (pop),
        .D_pop    (D_pop),
        .pndng    (pndng),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           src;
        logic [W-1:0] pkt;
        logic [N-1:0] exp_pndng;
        bit           drop;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [W-1:0] mk(input int tgt, input int src, input logic [59:0] pl);
        return {3'(tgt), 2'(src), pl};
    endfunction

    function automatic logic [W-1:0] popd(input int j);
        return D_pop[j*W +: W];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        push   = '0;
        pop    = '0;
        D_push = '0;
    endtask

    task automatic rst_pulse;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           exp_drop;
        int           cnt [N];
        int           acc, rx, guard;
        logic [W-1:0] hd;
        logic [W-1:0] fresh;

        vecs[0] = '{0, mk(1, 0, 60'h0),    4'b0010, 1'b0};
        vecs[1] = '{1, mk(1, 1, 60'h123),  4'b0010, 1'b0};
        vecs[2] = '{3, mk(0, 3, 60'hDEAD), 4'b0001, 1'b0};
        vecs[3] = '{2, mk(7, 2, 60'hABC),  4'b1011, 1'b0};
        vecs[4] = '{0, mk(7, 0, 60'h55),   4'b1110, 1'b0};
        vecs[5] = '{1, mk(5, 1, 60'h1),    4'b0000, 1'b1};
        vecs[6] = '{3, mk(6, 3, 60'h2),    4'b0000, 1'b1};
        vecs[7] = '{2, mk(3, 2, 60'hF00D), 4'b1000, 1'b0};

        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_full",  full, 0);
        chk("rst_pndng", pndng, 0);
        chk("rst_ovf",   ovf, 0);
        chk("rst_drop",  drop_cnt, 0);
        chk("rst_dpop",  |D_pop, 0);

        exp_drop = 0;
        for (int i = 0; i < 8; i++) begin
            D_push[vecs[i].src*W +: W] = vecs[i].pkt;
            push[vecs[i].src] = 1'b1;
            tick();
            idle();
            chk($sformatf("v%0d_latency", i), pndng, 0);
            tick();
            if (vecs[i].drop) exp_drop++;
            chk($sformatf("v%0d_pndng", i), pndng, vecs[i].exp_pndng);
            chk($sformatf("v%0d_drop", i), drop_cnt, exp_drop);
            for (int j = 0; j < N; j++)
                if (vecs[i].exp_pndng[j]) chk($sformatf("v%0d_data%0d", i, j), popd(j), vecs[i].pkt);
            pop = vecs[i].exp_pndng;
            tick();
            pop = '0;
            chk($sformatf("v%0d_popped", i), pndng, 0);
            chk($sformatf("v%0d_ovf", i), ovf, 0);
        end

        // Fairness: every terminal targets 3 each cycle while 3 is drained.
        rst_pulse();
        for (int i = 0; i < N; i++) begin
            D_push[i*W +: W] = mk(3, i, 60'(i));
            cnt[i] = 0;
        end
        push   = '1;
        pop[3] = 1'b1;
        tick();
        chk("rr_first", pndng[3], 0);
        for (int k = 0; k < 64; k++) begin
            tick();
            hd = popd(3);
            chk($sformatf("rr_order%0d", k), {pndng[3], hd[61:60]}, {1'b1, 2'(k % 4)});
            cnt[hd[61:60]]++;
        end
        for (int i = 0; i < N; i++) chk($sformatf("rr_share%0d", i), cnt[i], 16);

        // Backpressure: terminal 1 never popped until both FIFOs are full.
        rst_pulse();
        acc   = 0;
        guard = 0;
        while (full[0] == 1'b0 && guard < 40) begin
            D_push[0 +: W] = mk(1, 0, 60'(acc));
            push[0] = 1'b1;
            tick();
            acc++;
            guard++;
        end
        idle();
        chk("bp_accepted", acc, 16);
        chk("bp_full0", full[0], 1);
        chk("bp_pndng1", pndng[1], 1);
        chk("bp_ovf_pre", ovf[0], 0);
        D_push[0 +: W] = mk(1, 0, 60'd16);
        push[0] = 1'b1;
        tick();
        idle();
        chk("bp_ovf_set", ovf[0], 1);
        chk("bp_still_full", full[0], 1);
        rx    = 0;
        guard = 0;
        pop[1] = 1'b1;
        while (rx < 16 && guard < 80) begin
            if (pndng[1]) begin
                hd = popd(1);
                chk($sformatf("bp_order%0d", rx), hd[59:0], rx);
                rx++;
            end
            tick();
            guard++;
        end
        pop[1] = 1'b0;
        tick();
        chk("bp_rx", rx, 16);
        chk("bp_drained", pndng[1], 0);
        hd = popd(1);
        chk("bp_hold_last", hd[59:0], 15);
        chk("bp_full_clr", full[0], 0);
        chk("bp_ovf_sticky", ovf[0], 1);

        // Reset mid-operation with packets queued.
        D_push[2*W +: W] = mk(6, 2, 60'h9);
        push[2] = 1'b1;
        tick();
        idle();
        tick();
        chk("mr_drop1", drop_cnt, 1);
        for (int i = 0; i < 3; i++) D_push[i*W +: W] = mk(3, i, 60'(100 + i));
        push = 4'b0111;
        tick();
        idle();
        tick();
        chk("mr_inflight", pndng[3], 1);
        rst_pulse();
        chk("mr_pndng", pndng, 0);
        chk("mr_full",  full, 0);
        chk("mr_ovf",   ovf, 0);
        chk("mr_drop",  drop_cnt, 0);
        chk("mr_dpop",  |D_pop, 0);
        tick();
        tick();
        chk("mr_flushed", pndng, 0);
        fresh = mk(2, 1, 60'h777);
        D_push[1*W +: W] = fresh;
        push[1] = 1'b1;
        tick();
        idle();
        tick();
        chk("mr_fresh_pndng", pndng, 4'b0100);
        chk("mr_fresh_data", popd(2), fresh);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
